// File: rtl/osc_capture_ctrl_if.sv
// Purpose : sample-path and control bundle between the capture sequencer and its environment.
// Latency : n/a (signal bundle only).
// Backpressure: none; the buffer write port is fire-and-forget, frame_done releases a frozen capture.
//
// Ports (slave = sequencer side):
//   in_x/in_y, trigger, trig_fall, mode, arm, frame_done  -> into the sequencer
//   write_en, wr_addr, out_x, out_y, start_addr,
//   capture_done, auto_trig, busy                          <- out of the sequencer
interface osc_capture_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_x;
    logic [7:0]        in_y;
    logic              trigger;
    logic              trig_fall;
    logic [1:0]        mode;
    logic              arm;
    logic              frame_done;
    logic              write_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        out_x;
    logic [7:0]        out_y;
    logic [ADDR_W-1:0] start_addr;
    logic              capture_done;
    logic              auto_trig;
    logic              busy;

    // Stimulus / environment side.
    modport master (
        output in_x, in_y, trigger, trig_fall, mode, arm, frame_done,
        input  write_en, wr_addr, out_x, out_y, start_addr, capture_done, auto_trig, busy
    );

    // Capture sequencer side.
    modport slave (
        input  in_x, in_y, trigger, trig_fall, mode, arm, frame_done,
        output write_en, wr_addr, out_x, out_y, start_addr, capture_done, auto_trig, busy
    );
endinterface

// File: rtl/osc_capture_ctrl.sv
// Purpose : oscilloscope capture sequencer; fills a circular buffer with PRE history samples,
//           waits for a synchronised trigger edge (or auto timeout), writes the post-trigger tail, then freezes.
// Latency : samples delayed 1 cycle; trigger edge seen 2 cycles after first sampling; capture_done 1 cycle after last write.
// Backpressure: none on samples; a frozen capture is held until frame_done.
//
// Ports: clk_62_5 / rst_n (async, active-low) plain; everything else through osc_capture_ctrl_if.slave.
module osc_capture_ctrl #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int PRE          = 64,
    parameter int AUTO_TIMEOUT = 4096,
    parameter int TO_W         = 13
) (
    input  logic              clk_62_5,
    input  logic              rst_n,
    osc_capture_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_HOLD
    } state_t;

    localparam int                POST_LEN  = DEPTH - PRE - 1;
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE - 1);
    localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);
    localparam logic [TO_W-1:0]   T_ONE     = TO_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);
    // With no pre-trigger history the PRETRIG phase is skipped entirely.
    localparam state_t            FIRST_ST  = (PRE == 0) ? S_ARMED : S_PRETRIG;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;          // [0],[1] synchroniser, [2] history
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              auto_q, auto_d;
    logic              auto_en_q, auto_en_d;  // mode latched at the IDLE/HOLD exit decision
    logic              done_q, done_d;
    logic [7:0]        out_x_q, out_y_q;
    logic              wr_en;
    logic              trig_edge;
    logic              fire;
    logic              is_single;
    logic              is_auto;

    assign is_single = (bus.mode == 2'b10);
    assign is_auto   = (bus.mode == 2'b01);
    assign trig_edge = bus.trig_fall ? (~sync_q[1] & sync_q[2]) : (sync_q[1] & ~sync_q[2]);
    assign wr_en     = (state_q == S_PRETRIG) || (state_q == S_ARMED) || (state_q == S_POST);

    always_ff @(posedge clk_62_5 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            wr_addr_q    <= '0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            to_cnt_q     <= '0;
            auto_q       <= 1'b0;
            auto_en_q    <= 1'b0;
            done_q       <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[1:0], bus.trigger};
            trig_addr_q  <= trig_addr_d;
            start_addr_q <= start_addr_d;
            pre_cnt_q    <= pre_cnt_d;
            post_cnt_q   <= post_cnt_d;
            to_cnt_q     <= to_cnt_d;
            auto_q       <= auto_d;
            auto_en_q    <= auto_en_d;
            done_q       <= done_d;
            out_x_q      <= bus.in_x;
            out_y_q      <= bus.in_y;
            if (wr_en) begin
                wr_addr_q <= wr_addr_q + A_ONE;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        post_cnt_d   = post_cnt_q;
        to_cnt_d     = '0;             // timeout only accumulates across consecutive ARMED cycles
        trig_addr_d  = trig_addr_q;
        start_addr_d = start_addr_q;
        auto_d       = auto_q;
        auto_en_d    = auto_en_q;
        fire         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!is_single || bus.arm) begin
                    state_d   = FIRST_ST;
                    auto_en_d = is_auto;
                end
            end
            S_PRETRIG: begin
                if (pre_cnt_q == PRE_LAST) begin
                    state_d = S_ARMED;
                end else begin
                    pre_cnt_d = pre_cnt_q + A_ONE;
                end
            end
            S_ARMED: begin
                // A real edge wins over a coincident timeout, so auto_trig only marks pure timeouts.
                fire = trig_edge || (auto_en_q && (to_cnt_q == TO_LAST));
                if (fire) begin
                    trig_addr_d = wr_addr_q;
                    post_cnt_d  = '0;
                    auto_d      = ~trig_edge;
                    if (POST_LEN == 0) begin
                        state_d      = S_HOLD;
                        start_addr_d = wr_addr_q - PRE_A;
                    end else begin
                        state_d = S_POST;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + T_ONE;
                end
            end
            S_POST: begin
                if (post_cnt_q == POST_LAST) begin
                    state_d      = S_HOLD;
                    start_addr_d = trig_addr_q - PRE_A;  // wraps naturally mod DEPTH
                end else begin
                    post_cnt_d = post_cnt_q + A_ONE;
                end
            end
            S_HOLD: begin
                if (bus.frame_done) begin
                    state_d   = is_single ? S_IDLE : FIRST_ST;
                    auto_en_d = is_auto;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_PRETRIG) && (state_q != S_PRETRIG)) begin
            pre_cnt_d = '0;
        end
    end

    assign done_d = (state_d == S_HOLD) && (state_q != S_HOLD);

    assign bus.write_en     = wr_en;
    assign bus.busy         = wr_en;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.out_x        = out_x_q;
    assign bus.out_y        = out_y_q;
    assign bus.start_addr   = start_addr_q;
    assign bus.capture_done = done_q;
    assign bus.auto_trig    = auto_q;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Purpose : directed self-checking bench for osc_capture_ctrl with sample and capture scoreboards.
// Latency : samples expected one cycle after they are driven; trigger write expected 2..3 cycles after trigger change.
// Backpressure: frame_done pulses release each frozen capture.
module tb_osc_capture_ctrl;

    localparam int DEPTH        = 256;
    localparam int ADDR_W       = 8;
    localparam int PRE          = 64;
    localparam int AUTO_TIMEOUT = 4096;
    localparam int TO_W         = 13;
    localparam int POST_LEN     = DEPTH - PRE - 1;

    logic clk_62_5 = 1'b0;
    logic rst_n    = 1'b1;

    always #8 clk_62_5 = ~clk_62_5;

    osc_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    osc_capture_ctrl #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .PRE         (PRE),
        .AUTO_TIMEOUT(AUTO_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk_62_5(clk_62_5),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int auto_exp;
        int n_exp;   // total writes of the capture, -1 when not fixed
        int lo;      // trigger-write cycle window, -1 when not fixed
        int hi;
    } cap_exp_t;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          cap_cnt = 0;
    int          nwr = 0;
    int          exp_addr = 0;
    logic [15:0] sq[$];
    cap_exp_t    capq[$];
    int          wc[$];
    int          wa[$];
    bit          frozen = 1'b0;
    bit          prev_we = 1'b0;
    bit          prev_done = 1'b0;
    logic [15:0] smp;
    cap_exp_t    ce;
    int          n_w, ti;
    int          c0, n0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void push_cap(input int a, input int n, input int lo, input int hi);
        cap_exp_t e;
        e.auto_exp = a;
        e.n_exp    = n;
        e.lo       = lo;
        e.hi       = hi;
        capq.push_back(e);
    endfunction

    always @(posedge clk_62_5) cyc <= cyc + 1;

    // Monitor: sample scoreboard, address continuity, capture scoreboard, freeze behaviour.
    always @(posedge clk_62_5) begin
        #1;
        if (!rst_n) begin
            sq.delete();
            wc.delete();
            wa.delete();
            exp_addr  = 0;
            frozen    = 1'b0;
            prev_we   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (sq.size() > 0) begin
                smp = sq.pop_front();
                check("sample", {bus.out_x, bus.out_y}, smp);
            end
            if (bus.write_en) begin
                if (!prev_we) begin
                    wc.delete();
                    wa.delete();
                end
                check("wr_addr", bus.wr_addr, exp_addr);
                wc.push_back(cyc);
                wa.push_back(int'(bus.wr_addr));
                exp_addr = (exp_addr + 1) % DEPTH;
                nwr++;
            end
            if (bus.capture_done) begin
                cap_cnt++;
                check("done_after_last_write", prev_we, 1);
                check("busy_at_done", bus.busy, 0);
                check("capq_nonempty", capq.size() > 0, 1);
                if (capq.size() > 0) begin
                    ce  = capq.pop_front();
                    n_w = wc.size();
                    ti  = n_w - 1 - POST_LEN;   // trigger write: exactly POST_LEN writes follow it
                    check("pretrig_len", ti >= PRE, 1);
                    check("auto_trig", bus.auto_trig, ce.auto_exp);
                    if (ce.n_exp >= 0) check("total_writes", n_w, ce.n_exp);
                    if (ti >= 0) begin
                        check("start_addr", bus.start_addr, (wa[ti] - PRE + DEPTH) % DEPTH);
                        if (ce.lo >= 0) check("trig_latency", (wc[ti] >= ce.lo) && (wc[ti] <= ce.hi), 1);
                    end
                end
                frozen = 1'b1;
            end else if (frozen) begin
                if (bus.frame_done) begin
                    frozen = 1'b0;
                    check("rearm_write", bus.write_en, bus.mode != 2'b10);
                end else begin
                    check("hold_write_en", bus.write_en, 0);
                    check("hold_busy", bus.busy, 0);
                end
            end
            if (prev_done) check("done_pulse_width", bus.capture_done, 0);
            prev_we   = bus.write_en;
            prev_done = bus.capture_done;
        end
    end

    task automatic step();
        @(negedge clk_62_5);
        bus.in_x = 8'($urandom);
        bus.in_y = 8'($urandom);
        if (rst_n) sq.push_back({bus.in_x, bus.in_y});
    endtask

    task automatic wait_n(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_fd();
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    // Change the trigger level and expect the trigger write 2..3 cycles later.
    task automatic set_trig(input logic v);
        bus.trigger = v;
        push_cap(0, -1, cyc + 2, cyc + 3);
    endtask

    task automatic wait_cap(input int budget);
        int k0, k;
        k0 = cap_cnt;
        k  = 0;
        while ((cap_cnt == k0) && (k < budget)) begin
            step();
            k++;
        end
        check("capture_seen", cap_cnt - k0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk_62_5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_write_en", bus.write_en, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_y", bus.out_y, 0);
        check("rst_start_addr", bus.start_addr, 0);
        check("rst_capture_done", bus.capture_done, 0);
        check("rst_auto_trig", bus.auto_trig, 0);
        check("rst_busy", bus.busy, 0);
        sq.delete();
        capq.delete();
        repeat (3) @(posedge clk_62_5);
        #3;
        rst_n = 1'b1;
        check("idle_after_release", bus.write_en, 0);
        step();
        @(posedge clk_62_5);
        #2;
        check("startup_pretrig", bus.write_en, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_x       = '0;
        bus.in_y       = '0;
        bus.trigger    = 1'b0;
        bus.trig_fall  = 1'b0;
        bus.mode       = 2'b00;
        bus.arm        = 1'b0;
        bus.frame_done = 1'b0;

        // Reset values and normal-mode start-up.
        do_reset();

        // Normal mode, rising edge ~500 cycles after reset.
        wait_n(500);
        set_trig(1'b1);
        wait_cap(600);
        wait_n(20);
        bus.trigger = 1'b0;
        wait_n(10);
        pulse_fd();

        // Edge during PRETRIG ignored; toggles during POST ignored.
        wait_n(5);
        bus.trigger = 1'b1;
        wait_n(3);
        bus.trigger = 1'b0;
        wait_n(100);
        set_trig(1'b1);
        wait_n(60);
        repeat (4) begin
            bus.trigger = ~bus.trigger;
            wait_n(4);
        end
        wait_cap(400);
        bus.trigger = 1'b0;
        wait_n(10);

        // Falling-edge select: rise in ARMED ignored, fall triggers.
        bus.trig_fall = 1'b1;
        pulse_fd();
        wait_n(100);
        bus.trigger = 1'b1;
        wait_n(30);
        set_trig(1'b0);
        wait_cap(400);
        bus.trig_fall = 1'b0;
        wait_n(5);

        // Auto mode: timeout on the AUTO_TIMEOUT-th ARMED cycle, then a real edge clears auto_trig.
        bus.mode = 2'b01;
        push_cap(1, PRE + AUTO_TIMEOUT + POST_LEN, -1, -1);
        pulse_fd();
        wait_cap(AUTO_TIMEOUT + 500);
        wait_n(5);
        pulse_fd();
        wait_n(100);
        set_trig(1'b1);
        wait_cap(400);
        bus.trigger = 1'b0;
        wait_n(5);

        // Single mode: idle without arm, one capture per arm.
        bus.mode = 2'b10;
        pulse_fd();
        n0 = nwr;
        wait_n(1000);
        check("single_no_arm_writes", nwr - n0, 0);
        pulse_arm();
        check("arm_starts_pretrig", bus.write_en, 1);
        wait_n(100);
        set_trig(1'b1);
        wait_cap(400);
        bus.trigger = 1'b0;
        wait_n(5);
        pulse_arm();                 // ignored outside IDLE
        wait_n(5);
        pulse_fd();
        n0 = nwr;
        wait_n(50);
        check("single_back_to_idle", nwr - n0, 0);
        c0 = cap_cnt;
        pulse_arm();
        wait_n(100);
        set_trig(1'b1);
        wait_cap(400);
        check("single_two_captures", cap_cnt - c0, 1);
        bus.trigger = 1'b0;
        wait_n(5);

        // Reset during POST: capture abandoned, restart from address 0.
        bus.mode = 2'b00;
        pulse_fd();
        wait_n(100);
        bus.trigger = 1'b1;
        wait_n(50);
        bus.trigger = 1'b0;
        c0 = cap_cnt;
        do_reset();
        wait_n(150);
        check("no_done_after_reset", cap_cnt - c0, 0);
        set_trig(1'b1);
        wait_cap(400);
        bus.trigger = 1'b0;
        wait_n(5);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
